// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM frame demultiplexer.
package tdm_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } tdm_state_e;

  localparam int TDM_WIDTH_DEFAULT    = 8;
  localparam int TDM_CHANNELS_DEFAULT = 4;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index within a TDM frame, wrapping from CHANNELS-1 back to 0.
module tdm_slot_counter #(
  parameter int CHANNELS = 4,
  parameter int SW       = $clog2(CHANNELS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load1,
  input  logic          en,
  output logic [SW-1:0] slot
);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clear) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SW'(1);
    end else if (en) begin
      slot_d = (slot_q == SW'(CHANNELS - 1)) ? '0 : slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux.sv
// Reassembles a serial TDM sample stream into parallel frames, tracking
// frame alignment via in_sync and flagging alignment violations.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH    = TDM_WIDTH_DEFAULT,
  parameter int CHANNELS = TDM_CHANNELS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_sync,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic                      locked,
  output logic                      sync_err
);

  localparam int SW = $clog2(CHANNELS);

  tdm_state_e                state_q, state_d;
  logic [CHANNELS*WIDTH-1:0] staging_q, staging_d;
  logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      sync_err_q, sync_err_d;

  logic [SW-1:0]       slot;
  logic                cnt_clear, cnt_load1, cnt_en;
  logic                store0, store_slot, complete;
  logic [CHANNELS-1:0] wr_sel;

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SW       (SW)
  ) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .load1 (cnt_load1),
    .en    (cnt_en),
    .slot  (slot)
  );

  always_comb begin
    state_d    = state_q;
    sync_err_d = 1'b0;
    cnt_clear  = 1'b0;
    cnt_load1  = 1'b0;
    cnt_en     = 1'b0;
    store0     = 1'b0;
    store_slot = 1'b0;
    complete   = 1'b0;
    if (in_valid) begin
      if (state_q == UNLOCKED) begin
        if (in_sync) begin
          store0    = 1'b1;
          cnt_load1 = 1'b1;
          state_d   = LOCKED;
        end
      end else if (in_sync && slot != '0) begin
        // Resync: restart the frame from this sample, dropping the partial one.
        sync_err_d = 1'b1;
        store0     = 1'b1;
        cnt_load1  = 1'b1;
      end else if (!in_sync && slot == '0) begin
        sync_err_d = 1'b1;
        cnt_clear  = 1'b1;
        state_d    = UNLOCKED;
      end else begin
        store_slot = 1'b1;
        cnt_en     = 1'b1;
        complete   = (slot == SW'(CHANNELS - 1));
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    assign wr_sel[gi] = (store0 && gi == 0) || (store_slot && slot == SW'(gi));
    assign staging_d[gi*WIDTH +: WIDTH] = wr_sel[gi] ? in_data
                                                     : staging_q[gi*WIDTH +: WIDTH];
  end

  // staging_d already holds the final sample, so the whole frame lands at once.
  assign out_data_d  = complete ? staging_d : out_data_q;
  assign out_valid_d = complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      staging_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      staging_q   <= staging_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == LOCKED);
  assign sync_err  = sync_err_q;

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 WIDTH, default 8: bits per channel sample.
REQ-002 CHANNELS, default 4: slots per frame; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data/in_sync carry a slot sample this cycle.
REQ-006 in_data  input  WIDTH  serialized sample from the upstream time-division mux.
REQ-007 in_sync  input  1  marks the sample as slot 0 (frame start); ignored when in_valid=0.
REQ-008 out_data  output  CHANNELS*WIDTH  completed frame; channel k at bits [k*WIDTH +: WIDTH].
REQ-009 out_valid  output  1  one-cycle pulse when out_data has just been updated with a new frame.
REQ-010 locked  output  1  high while the FSM is in LOCKED.
REQ-011 sync_err  output  1  one-cycle pulse on a frame-alignment violation.

Function
REQ-012 The FSM SHALL have two states: UNLOCKED and LOCKED.
REQ-013 The slot counter SHALL be $clog2(CHANNELS) bits wide and SHALL advance only on accepted samples (in_valid=1).
REQ-014 In UNLOCKED, a sample with in_sync=1 SHALL be stored as channel 0, set slot=1 and move to LOCKED.
REQ-015 In UNLOCKED, samples with in_sync=0 SHALL be discarded silently, with no sync_err.
REQ-016 In LOCKED, a valid sample SHALL be written to the staging register at the current slot, and the slot SHALL then increment.
REQ-017 The slot SHALL wrap from CHANNELS-1 to 0.
REQ-018 When the sample in slot CHANNELS-1 is accepted, the full frame SHALL be copied to out_data atomically, with out_valid=1 in the following cycle (latency 1 clk from the last sample edge).
REQ-019 out_data SHALL hold its value between frames; partial frames SHALL never be visible on out_data.
REQ-020 In LOCKED, a sample with in_sync=1 at slot!=0 SHALL pulse sync_err, discard the partial frame, store the sample as channel 0, set slot=1 and stay in LOCKED (resync).
REQ-021 In LOCKED, a sample with in_sync=0 at slot=0 SHALL pulse sync_err, discard the sample and go to UNLOCKED.
REQ-022 Cycles with in_valid=0 (gaps) SHALL leave all state unchanged, in any slot.
REQ-023 The completing sample (slot CHANNELS-1) with in_sync=1 SHALL be handled as a resync per REQ-020; no frame SHALL be emitted.
REQ-024 out_valid and sync_err SHALL never both be asserted in the same cycle.

Reset
REQ-025 While rst=1: state=UNLOCKED, slot=0, staging=0, out_data=0, out_valid=0, locked=0, sync_err=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; no out_valid SHALL follow reset release until a complete new frame arrives.
REQ-027 Samples presented while rst=1 SHALL be ignored.

Structure
REQ-028 The package tdm_pkg SHALL hold the state enum (UNLOCKED, LOCKED) and the default WIDTH/CHANNELS constants.
REQ-029 The slot counter with wrap SHALL be a sub-module, tdm_slot_counter (inputs: clk, rst, clear, load1, en; output: slot).
REQ-030 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Verification (WIDTH=8, CHANNELS=4)
REQ-031 Reset, then in_valid=1 samples {sync:A0}, B1, C2, D3 on consecutive cycles -> out_data=0xD3C2B1A0 and out_valid=1 for exactly one cycle, one clk after D3; locked=1 from the cycle after A0.
REQ-032 Same frame with in_valid=0 gaps of 1 and 3 cycles between slots -> identical out_data, out_valid pulses once, one clk after D3.
REQ-033 Frame 11,22, then {sync:33},44,55,66 -> sync_err pulses once, then out_data=0x66554433 and no frame containing 0x11 is emitted.
REQ-034 A full frame followed by a slot-0 sample with in_sync=0 -> sync_err pulse, locked=0, out_data keeps its previous frame; non-sync samples afterwards are ignored until the next sync.
REQ-035 rst=1 for one cycle after slot 2 of a frame -> all outputs 0; the next full synced frame 01,02,03,04 gives out_data=0x04030201.
REQ-036 Before any sync, 10 random samples with in_sync=0 -> locked=0, no out_valid, no sync_err.
